// File: rtl/useq_sequencer.sv
// Microcoded sequencer: writable control store, condition mux, return stack and loop counter.
// Optional macro USEQ_STACK_CHECK_EN traps stack overflow/underflow into a sticky err flag.
module useq_sequencer #(
  parameter int  P_LOG_MEMSIZE    = 4,
  parameter int  P_NUM_D_CTRLBITS = 5,
  parameter int  P_NUM_COND       = 4,
  parameter int  P_STACK_DEPTH    = 4,
  localparam int CW               = $clog2(P_NUM_COND),
  localparam int WORD             = P_NUM_D_CTRLBITS + 3 + CW + P_LOG_MEMSIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [P_NUM_COND-1:0]       cond,
  input  logic                        wr_en,
  input  logic [P_LOG_MEMSIZE-1:0]    wr_addr,
  input  logic [WORD-1:0]             wr_data,
  output logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl,
  output logic [P_LOG_MEMSIZE-1:0]    pc,
  output logic                        err
);

  localparam int DEPTH = 1 << P_LOG_MEMSIZE;
  localparam int SPW   = $clog2(P_STACK_DEPTH + 1);
  localparam int IW    = (P_STACK_DEPTH > 1) ? $clog2(P_STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_JUMP  = 3'd1,
    OP_JC    = 3'd2,
    OP_JNC   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_LDCNT = 3'd6,
    OP_DJNZ  = 3'd7
  } op_e;

  logic [WORD-1:0]          imem  [DEPTH];
  logic [P_LOG_MEMSIZE-1:0] stack [P_STACK_DEPTH];

  logic [P_LOG_MEMSIZE-1:0] pc_reg, pc_next;
  logic [P_LOG_MEMSIZE-1:0] cnt_reg, cnt_next;
  logic [SPW-1:0]           sp_reg, sp_next;
  logic [SPW-1:0]           sp_inc, sp_dec;
  logic [IW-1:0]            push_idx, pop_idx;
  logic                     push;
  logic                     advance;

  logic [WORD-1:0]          word;
  op_e                      op;
  logic [CW-1:0]            csel;
  logic [P_LOG_MEMSIZE-1:0] imm, pc_inc, cnt_dec;
  logic [(1<<CW)-1:0]       cond_ext;
  logic                     c;

  // Asynchronous fetch so dp_ctrl follows pc with no added latency
  assign word    = imem[pc_reg];
  assign dp_ctrl = word[WORD-1 -: P_NUM_D_CTRLBITS];
  assign op      = op_e'(word[P_LOG_MEMSIZE+CW +: 3]);
  assign csel    = word[P_LOG_MEMSIZE +: CW];
  assign imm     = word[P_LOG_MEMSIZE-1:0];
  assign pc      = pc_reg;
  assign pc_inc  = pc_reg + P_LOG_MEMSIZE'(1);
  assign cnt_dec = cnt_reg - P_LOG_MEMSIZE'(1);

  // Pad the condition vector to a power of two; unused selects read as 0
  genvar gi;
  for (gi = 0; gi < (1 << CW); gi++) begin : g_cond
    if (gi < P_NUM_COND) begin : g_real
      assign cond_ext[gi] = cond[gi];
    end else begin : g_pad
      assign cond_ext[gi] = 1'b0;
    end
  end
  assign c = cond_ext[csel];

`ifdef USEQ_STACK_CHECK_EN
  localparam logic [SPW-1:0] SP_FULL = SPW'(P_STACK_DEPTH);
  logic err_reg, err_next;

  assign sp_inc  = sp_reg + SPW'(1);
  assign sp_dec  = sp_reg - SPW'(1);
  assign advance = en & ~err_reg;
  assign err     = err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
`else
  localparam logic [SPW-1:0] SP_LAST = SPW'(P_STACK_DEPTH - 1);

  // Unchecked stack: pointer wraps, oldest entry is overwritten
  assign sp_inc  = (sp_reg == SP_LAST) ? '0 : sp_reg + SPW'(1);
  assign sp_dec  = (sp_reg == '0) ? SP_LAST : sp_reg - SPW'(1);
  assign advance = en;
  assign err     = 1'b0;
`endif

  assign push_idx = IW'(sp_reg);
  assign pop_idx  = IW'(sp_dec);

  always_comb begin
    pc_next  = pc_reg;
    sp_next  = sp_reg;
    cnt_next = cnt_reg;
    push     = 1'b0;
`ifdef USEQ_STACK_CHECK_EN
    err_next = err_reg;
`endif
    if (advance) begin
      case (op)
        OP_NEXT:  pc_next = pc_inc;
        OP_JUMP:  pc_next = imm;
        OP_JC:    pc_next = c ? imm : pc_inc;
        OP_JNC:   pc_next = c ? pc_inc : imm;
        OP_CALL: begin
`ifdef USEQ_STACK_CHECK_EN
          if (sp_reg == SP_FULL) begin
            err_next = 1'b1;
          end else begin
            push    = 1'b1;
            sp_next = sp_inc;
            pc_next = imm;
          end
`else
          push    = 1'b1;
          sp_next = sp_inc;
          pc_next = imm;
`endif
        end
        OP_RET: begin
`ifdef USEQ_STACK_CHECK_EN
          if (sp_reg == '0) begin
            err_next = 1'b1;
          end else begin
            sp_next = sp_dec;
            pc_next = stack[pop_idx];
          end
`else
          sp_next = sp_dec;
          pc_next = stack[pop_idx];
`endif
        end
        OP_LDCNT: begin
          cnt_next = imm;
          pc_next  = pc_inc;
        end
        OP_DJNZ: begin
          cnt_next = cnt_dec;
          pc_next  = (cnt_dec != '0) ? imm : pc_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg  <= '0;
      sp_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      pc_reg  <= pc_next;
      sp_reg  <= sp_next;
      cnt_reg <= cnt_next;
    end
  end

  // Host loader port works regardless of reset or enable
  always_ff @(posedge clk) begin
    if (wr_en) begin
      imem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Self-checking bench for useq_sequencer: directed scenarios plus randomized run
// against a queue/array based reference model.
module tb_useq_sequencer;
  localparam int LM  = 4;
  localparam int DB  = 5;
  localparam int NC  = 4;
  localparam int SD  = 4;
  localparam int CW  = 2;
  localparam int W   = DB + 3 + CW + LM;
  localparam int MEM = 16;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JC = 3'd2, JNC = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, LDCNT = 3'd6, DJNZ = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [NC-1:0] cond = '0;
  logic          wr_en = 1'b0;
  logic [LM-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [DB-1:0] dp_ctrl;
  logic [LM-1:0] pc;
  logic          err;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] prog [MEM];

  // Reference model state
  logic [W-1:0] m_mem [MEM];
  int m_pc = 0, m_cnt = 0, m_sp = 0;
  bit m_err = 1'b0, m_known = 1'b0;
  int m_q[$];
  int m_stk [SD];
  bit m_vld [SD];

  always #5 clk = ~clk;

  useq_sequencer #(
    .P_LOG_MEMSIZE(LM), .P_NUM_D_CTRLBITS(DB), .P_NUM_COND(NC), .P_STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .dp_ctrl(dp_ctrl), .pc(pc), .err(err)
  );

  function automatic logic [W-1:0] mk(int dp, logic [2:0] op, int cs, int imm);
    return {DB'(dp), op, CW'(cs), LM'(imm)};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    logic [W-1:0] w;
    int op, cs, imm, nx;
    bit c;
    w   = m_mem[m_pc];
    op  = int'(w[LM+CW +: 3]);
    cs  = int'(w[LM +: CW]);
    imm = int'(w[LM-1:0]);
    nx  = (m_pc + 1) % MEM;
    c   = (cs < NC) ? cond[cs] : 1'b0;
    if (!rst_n) begin
      m_pc = 0; m_cnt = 0; m_err = 1'b0; m_sp = 0; m_known = 1'b1;
      m_q.delete();
    end else if (en && !m_err) begin
      case (op)
        0: m_pc = nx;
        1: m_pc = imm;
        2: m_pc = c ? imm : nx;
        3: m_pc = c ? nx : imm;
        4: begin
`ifdef USEQ_STACK_CHECK_EN
          if (m_q.size() == SD) m_err = 1'b1;
          else begin m_q.push_back(nx); m_pc = imm; end
`else
          m_stk[m_sp] = nx; m_vld[m_sp] = 1'b1; m_sp = (m_sp + 1) % SD; m_pc = imm;
`endif
        end
        5: begin
`ifdef USEQ_STACK_CHECK_EN
          if (m_q.size() == 0) m_err = 1'b1;
          else m_pc = m_q.pop_back();
`else
          m_sp = (m_sp + SD - 1) % SD;
          if (!m_vld[m_sp]) m_known = 1'b0;
          m_pc = m_stk[m_sp];
`endif
        end
        6: begin m_cnt = imm; m_pc = nx; end
        default: begin
          m_cnt = (m_cnt + MEM - 1) % MEM;
          m_pc  = (m_cnt != 0) ? imm : nx;
        end
      endcase
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_next();
    for (int a = 0; a < MEM; a++) prog[a] = mk(a, NEXT, 0, 0);
  endtask

  // Loads the whole control store while holding reset; leaves rst_n low, pc=0
  task automatic load_prog();
    rst_n = 1'b0;
    en = 1'b0;
    for (int a = 0; a < MEM; a++) begin
      wr_en = 1'b1; wr_addr = LM'(a); wr_data = prog[a];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    fill_next();
    load_prog();
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (dp_ctrl !== 5'd0) begin failures++; $display("FAIL reset_dp: got %0d expected 0", dp_ctrl); end
    en = 1'b1;
    tick();
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL reset_over_en: got %0d expected 0", pc); end
    $display("txn reset pc=%0d err=%0b dp=%0d", pc, err, dp_ctrl);
  endtask

  task automatic test_next_wrap();
    fill_next();
    load_prog();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++; if (pc !== LM'(i % MEM)) begin failures++; $display("FAIL next_pc: got %0d expected %0d", pc, i % MEM); end
      checks++; if (dp_ctrl !== DB'(i % MEM)) begin failures++; $display("FAIL next_dp: got %0d expected %0d", dp_ctrl, i % MEM); end
    end
    repeat (6) tick();
    checks++; if (pc !== 4'd7) begin failures++; $display("FAIL next_pc7: got %0d expected 7", pc); end
    rst_n = 1'b0;
    tick();
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL midrun_reset: got %0d expected 0", pc); end
    rst_n = 1'b1;
    $display("txn next_wrap done pc=%0d", pc);
  endtask

  task automatic test_cond_branch();
    for (int k = 0; k < 4; k++) begin
      bit isjnc, b;
      int expv;
      isjnc = k[1]; b = k[0];
      fill_next();
      prog[2] = mk(2, isjnc ? JNC : JC, 1, 9);
      load_prog();
      cond = (NC'($urandom) & 4'b1101) | (b ? 4'b0010 : 4'b0000);
      rst_n = 1'b1; en = 1'b1;
      tick(); tick();
      checks++; if (pc !== 4'd2) begin failures++; $display("FAIL cond_pre: got %0d expected 2", pc); end
      tick();
      expv = ((b == 1'b1) != isjnc) ? 9 : 3;
      checks++; if (pc !== LM'(expv)) begin failures++; $display("FAIL cond_branch jnc=%0b c=%0b: got %0d expected %0d", isjnc, b, pc, expv); end
      $display("txn cond jnc=%0b c=%0b pc=%0d", isjnc, b, pc);
    end
  endtask

  task automatic test_call_ret();
    int seq [5] = '{1, 8, 12, 9, 2};
    fill_next();
    prog[1]  = mk(1, CALL, 0, 8);
    prog[8]  = mk(8, CALL, 0, 12);
    prog[12] = mk(12, RET, 0, 0);
    prog[9]  = mk(9, RET, 0, 0);
`ifdef USEQ_STACK_CHECK_EN
    prog[2]  = mk(2, RET, 0, 0);
`endif
    load_prog();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc !== LM'(seq[i])) begin failures++; $display("FAIL callret_pc step %0d: got %0d expected %0d", i, pc, seq[i]); end
    end
    tick();
`ifdef USEQ_STACK_CHECK_EN
    // Stack must be empty again, so this RET underflows
    checks++; if (err !== 1'b1 || pc !== 4'd2) begin failures++; $display("FAIL callret_empty: got err=%0b pc=%0d expected err=1 pc=2", err, pc); end
`else
    checks++; if (err !== 1'b0 || pc !== 4'd3) begin failures++; $display("FAIL callret_tail: got err=%0b pc=%0d expected err=0 pc=3", err, pc); end
`endif
    $display("txn call_ret pc=%0d err=%0b", pc, err);
  endtask

  task automatic test_loop();
    int seq [8] = '{1, 2, 1, 2, 1, 2, 3, 9};
    fill_next();
    prog[0] = mk(0, LDCNT, 0, 3);
    prog[2] = mk(2, DJNZ, 0, 1);
    prog[3] = mk(3, DJNZ, 0, 9);  // cnt==0 wraps to 15, so this branches
    load_prog();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (pc !== LM'(seq[i])) begin failures++; $display("FAIL loop_pc step %0d: got %0d expected %0d", i, pc, seq[i]); end
    end
    $display("txn loop pc=%0d", pc);
  endtask

  task automatic test_en_hazard();
    fill_next();
    prog[5] = mk(5, JUMP, 0, 5);
    load_prog();
    rst_n = 1'b1; en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc !== 4'd3) begin failures++; $display("FAIL en_hold: got %0d expected 3", pc); end
    end
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = mk(17, NEXT, 0, 0);
    tick();
    wr_en = 1'b0;
    checks++; if (pc !== 4'd3 || dp_ctrl !== 5'd17) begin failures++; $display("FAIL en_write: got pc=%0d dp=%0d expected pc=3 dp=17", pc, dp_ctrl); end
    en = 1'b1;
    tick(); tick();
    checks++; if (pc !== 4'd5) begin failures++; $display("FAIL hz_pre: got %0d expected 5", pc); end
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = mk(22, NEXT, 0, 0);
    tick();
    wr_en = 1'b0;
    checks++; if (pc !== 4'd5 || dp_ctrl !== 5'd22) begin failures++; $display("FAIL hz_oldop: got pc=%0d dp=%0d expected pc=5 dp=22", pc, dp_ctrl); end
    tick();
    checks++; if (pc !== 4'd6) begin failures++; $display("FAIL hz_newop: got %0d expected 6", pc); end
    $display("txn en_hazard pc=%0d dp=%0d", pc, dp_ctrl);
  endtask

  task automatic test_stack_fault();
    fill_next();
    for (int a = 0; a < 5; a++) prog[a] = mk(a, CALL, 0, a + 1);
    prog[5] = mk(5, RET, 0, 0);
    load_prog();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== LM'(i) || err !== 1'b0) begin failures++; $display("FAIL nest_call %0d: got pc=%0d err=%0b expected pc=%0d err=0", i, pc, err, i); end
    end
`ifdef USEQ_STACK_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== 4'd4 || err !== 1'b1) begin failures++; $display("FAIL overflow_freeze: got pc=%0d err=%0b expected pc=4 err=1", pc, err); end
    end
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = mk(30, NEXT, 0, 0);
    tick();
    wr_en = 1'b0;
    checks++; if (dp_ctrl !== 5'd30 || pc !== 4'd4) begin failures++; $display("FAIL frozen_write: got dp=%0d pc=%0d expected dp=30 pc=4", dp_ctrl, pc); end
    rst_n = 1'b0;
    tick();
    checks++; if (err !== 1'b0 || pc !== 4'd0) begin failures++; $display("FAIL err_clear: got err=%0b pc=%0d expected err=0 pc=0", err, pc); end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = mk(0, RET, 0, 7);
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (err !== 1'b1 || pc !== 4'd0) begin failures++; $display("FAIL underflow: got err=%0b pc=%0d expected err=1 pc=0", err, pc); end
`else
    tick();
    checks++; if (pc !== 4'd5 || err !== 1'b0) begin failures++; $display("FAIL wrap_call: got pc=%0d err=%0b expected pc=5 err=0", pc, err); end
    tick();
    checks++; if (pc !== 4'd5) begin failures++; $display("FAIL wrap_ret1: got %0d expected 5", pc); end
    tick();
    checks++; if (pc !== 4'd4 || err !== 1'b0) begin failures++; $display("FAIL wrap_ret2: got pc=%0d err=%0b expected pc=4 err=0", pc, err); end
`endif
    $display("txn stack_fault pc=%0d err=%0b", pc, err);
  endtask

  task automatic test_random();
    logic [DB-1:0] exp_dp;
    for (int a = 0; a < MEM; a++) prog[a] = W'($urandom);
    load_prog();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom % 8) != 0;
      cond    = NC'($urandom);
      wr_en   = ($urandom % 10) == 0;
      wr_addr = LM'($urandom);
      wr_data = W'($urandom);
      rst_n   = ($urandom % 40) != 0;
      tick();
      if (m_known) begin
        exp_dp = m_mem[m_pc][W-1 -: DB];
        checks++; if (pc !== LM'(m_pc)) begin failures++; $display("FAIL rnd_pc %0d: got %0d expected %0d", i, pc, m_pc); end
        checks++; if (dp_ctrl !== exp_dp) begin failures++; $display("FAIL rnd_dp %0d: got %0d expected %0d", i, dp_ctrl, exp_dp); end
        checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err %0d: got %0b expected %0b", i, err, m_err); end
      end
      $display("txn rnd %0d rst_n=%0b en=%0b wr=%0b pc=%0d dp=%0d err=%0b", i, rst_n, en, wr_en, pc, dp_ctrl, err);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_next_wrap();
    test_cond_branch();
    test_call_ret();
    test_loop();
    test_en_hazard();
    test_stack_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
